bip_control: RTL and testbench
==============================

# bip_control

Fetch/decode/sequencing unit of the BIP processor. Owns the program counter, drives the address of the synchronous-read program memory, and captures the 16-bit instruction it returns one cycle later. Decodes that instruction into datapath controls: accumulator mux and write, ALU op, and data-RAM read/write. Also keeps the run-cycle counter that reports execution length.

## Interface
- AB, 11: program-memory address width (PC width).
- DB, 16: instruction and data word width.
- OPW, 5: opcode width (instruction bits [DB-1:DB-OPW]).
- CW, 16: cycle-counter width.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution from IDLE.
- pm_data  in  DB  instruction from program memory; valid the cycle after pm_addr is presented.
- pm_addr  out  AB  program-memory address, equals PC.
- dm_addr  out  DB-OPW  data-RAM address, equals IR operand.
- operand_ext  out  DB  IR operand sign-extended to DB.
- sel_a  out  2  accumulator source: 0 = data RAM, 1 = operand_ext, 2 = ALU result.
- sel_b  out  1  ALU B source: 0 = data RAM, 1 = operand_ext.
- alu_op  out  1  0 = add, 1 = subtract.
- wr_acc  out  1  accumulator write enable.
- rd_ram  out  1  data-RAM read enable.
- wr_ram  out  1  data-RAM write enable (stores accumulator).
- halted  out  1  high while in HALT.
- cycle_count  out  CW  run-cycle counter.

## Operation
- Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI. All other opcodes are NOPs: no enables, PC+1.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: PC=0, all enables low. start → FETCH. Without start, stay in IDLE.
- FETCH: pm_addr=PC. The memory registers Mem[PC] at the end of this cycle. → DECODE.
- DECODE: pm_data valid. IR <= pm_data. → EXEC.
- EXEC, by IR opcode:
  - LDI: sel_a=1, wr_acc=1.
  - ADDI/SUBI: sel_b=1, alu_op=0/1, sel_a=2, wr_acc=1.
  - STO: wr_ram=1.
  - NOP: no enables.
  - For all of the above: PC <= PC+1, → FETCH.
  - LD/ADD/SUB: rd_ram=1, → WB, PC unchanged.
  - HLT: → HALT, PC unchanged.
- WB:
  - LD: sel_a=0, wr_acc=1.
  - ADD/SUB: sel_b=0, alu_op=0/1, sel_a=2, wr_acc=1.
  - PC <= PC+1, → FETCH.
- HALT: sticky until reset; halted=1; all enables low; start ignored.
- start outside IDLE is ignored.
- PC is AB bits and wraps: 2^AB-1 + 1 → 0.
- cycle_count increments by 1 in every FETCH/DECODE/EXEC/WB cycle. It is frozen in IDLE and HALT and saturates at all-ones.
- sel_a, sel_b and alu_op are don't-care when their enables are low; drive them to 0 then.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, cycle_count=0, pm_addr=0, dm_addr=0, operand_ext=0, all enables 0, halted=0.
- Reset asserted in any state, including mid-instruction, takes effect at the next posedge. No partial write is issued in the cycle after reset.
- All control outputs are combinational from state and IR only, never from pm_data. They are valid for exactly one cycle per instruction.
- Cycles per instruction: 3 for LDI/ADDI/SUBI/STO/NOP, 4 for LD/ADD/SUB. HLT spends 3 counted cycles, then HALT.
- First pm_addr sample happens in the cycle after start is accepted.
- dm_addr and operand_ext are stable from EXEC through WB.

## Structure
- Shared package bip_pkg holds: opcode constants, state encoding, sel_a/sel_b encodings, and default widths AB, DB, OPW.
- One combinational sub-module, bip_decoder, maps opcode and phase (EXEC/WB) to {sel_a, sel_b, alu_op, wr_acc, rd_ram, wr_ram, needs_wb, is_halt}.
- The FSM, PC, IR and counter live in bip_control.

## Test plan
- Reset then start with a bench memory model of 1-cycle read latency; Mem[0]=LDI 5, Mem[1]=HLT → wr_acc pulse with sel_a=1 and operand_ext=0x0005; halted rises; cycle_count=6 and frozen.
- LDI 0x7FF (operand −1) → operand_ext=0xFFFF. ADDI 3 → sel_b=1, alu_op=0, sel_a=2, wr_acc for one cycle.
- LD 0x018 then SUB 0x018 → rd_ram=1 and dm_addr=0x018 in EXEC; wr_acc in the following WB; 4 counted cycles each.
- STO 0x060 → single wr_ram pulse with dm_addr=0x060, no wr_acc; undefined opcode 11111 → no enables, PC advances by 1.
- Preload PC run to address 2047 with NOPs → pm_addr wraps to 0.
- Assert reset during WB of ADD → no wr_acc in the next cycle; all outputs at reset values.
- start pulses while running or halted are ignored.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg: shared widths, opcodes, FSM states and mux encodings for the BIP control unit.
package bip_pkg;
  localparam int AB = 11;
  localparam int DB = 16;
  localparam int OPW = 5;
  localparam int CW = 16;
  localparam logic [OPW-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPW-1:0] OP_STO  = 5'b00001;
  localparam logic [OPW-1:0] OP_LD   = 5'b00010;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPW-1:0] OP_SUBI = 5'b00111;
  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: maps opcode and execution phase to datapath controls and sequencing hints.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPW-1:0] op_i,
  input  logic           exec_i,
  input  logic           wb_i,
  output logic [1:0]     sel_a_o,
  output logic           sel_b_o,
  output logic           alu_op_o,
  output logic           wr_acc_o,
  output logic           rd_ram_o,
  output logic           wr_ram_o,
  output logic           needs_wb_o,
  output logic           is_halt_o
);
  logic is_ldi, is_imm_alu, is_ld, is_ram_alu;
  always_comb begin
    is_ldi     = op_i == OP_LDI;
    is_imm_alu = op_i == OP_ADDI || op_i == OP_SUBI;
    is_ld      = op_i == OP_LD;
    is_ram_alu = op_i == OP_ADD || op_i == OP_SUB;
    needs_wb_o = is_ld || is_ram_alu;
    is_halt_o  = op_i == OP_HLT;
    wr_acc_o   = (exec_i && (is_ldi || is_imm_alu)) || (wb_i && needs_wb_o);
    rd_ram_o   = exec_i && needs_wb_o;
    wr_ram_o   = exec_i && op_i == OP_STO;
    sel_b_o    = exec_i && is_imm_alu ? SEL_B_IMM : SEL_B_RAM;
    alu_op_o   = (exec_i && op_i == OP_SUBI) || (wb_i && op_i == OP_SUB);
    sel_a_o    = (exec_i && is_imm_alu) || (wb_i && is_ram_alu) ? SEL_A_ALU :
                 exec_i && is_ldi ? SEL_A_IMM : SEL_A_RAM;
  end
endmodule

// File: rtl/bip_control.sv
// bip_control: BIP fetch/decode/sequencing unit owning PC, IR and the run-cycle counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int AB  = bip_pkg::AB,
  parameter int DB  = bip_pkg::DB,
  parameter int OPW = bip_pkg::OPW,
  parameter int CW  = bip_pkg::CW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DB-1:0]     pm_data,
  output logic [AB-1:0]     pm_addr,
  output logic [DB-OPW-1:0] dm_addr,
  output logic [DB-1:0]     operand_ext,
  output logic [1:0]        sel_a,
  output logic              sel_b,
  output logic              alu_op,
  output logic              wr_acc,
  output logic              rd_ram,
  output logic              wr_ram,
  output logic              halted,
  output logic [CW-1:0]     cycle_count
);
  localparam int OW = DB - OPW;
  state_e        state_q;
  logic [AB-1:0] pc_q;
  logic [DB-1:0] ir_q;
  logic [CW-1:0] cnt_q;
  logic          exec, wb, needs_wb, is_halt, running;
  assign exec        = state_q == S_EXEC;
  assign wb          = state_q == S_WB;
  assign running     = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
  assign pm_addr     = pc_q;
  assign dm_addr     = ir_q[OW-1:0];
  assign operand_ext = {{OPW{ir_q[OW-1]}}, ir_q[OW-1:0]};
  assign halted      = state_q == S_HALT;
  assign cycle_count = cnt_q;
  bip_decoder u_dec (
    .op_i      (ir_q[DB-1 -: OPW]),
    .exec_i    (exec),
    .wb_i      (wb),
    .sel_a_o   (sel_a),
    .sel_b_o   (sel_b),
    .alu_op_o  (alu_op),
    .wr_acc_o  (wr_acc),
    .rd_ram_o  (rd_ram),
    .wr_ram_o  (wr_ram),
    .needs_wb_o(needs_wb),
    .is_halt_o (is_halt)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (running && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          pc_q <= '0;
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= pm_data;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_halt) state_q <= S_HALT;
          else if (needs_wb) state_q <= S_WB;
          else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          pc_q    <= pc_q + 1'b1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed bench for bip_control with a 1-cycle-latency program memory model.
module tb_bip_control;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pm_data;
  logic [10:0] pm_addr;
  logic [10:0] dm_addr;
  logic [15:0] operand_ext;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, wr_acc, rd_ram, wr_ram, halted;
  logic [15:0] cycle_count;
  logic [6:0]  ctrl;
  logic [15:0] mem [0:2047];
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;

  bip_control dut (
    .clk(clk), .reset(reset), .start(start), .pm_data(pm_data),
    .pm_addr(pm_addr), .dm_addr(dm_addr), .operand_ext(operand_ext),
    .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op), .wr_acc(wr_acc),
    .rd_ram(rd_ram), .wr_ram(wr_ram), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pm_data <= mem[pm_addr];
  assign ctrl = {sel_a, sel_b, alu_op, wr_acc, rd_ram, wr_ram};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic run_instr(input string tag, input int pc, input int dm, input int ext,
                           input logic [6:0] exec_ctrl, input bit has_wb, input logic [6:0] wb_ctrl);
    check({tag, " fetch pc"}, pm_addr, pc);
    check({tag, " fetch ctrl"}, ctrl, 0);
    check({tag, " fetch cnt"}, cycle_count, exp_cnt);
    tick();
    check({tag, " decode ctrl"}, ctrl, 0);
    tick();
    check({tag, " exec ctrl"}, ctrl, exec_ctrl);
    check({tag, " exec dm"}, dm_addr, dm);
    check({tag, " exec ext"}, operand_ext, ext);
    exp_cnt += 3;
    tick();
    if (has_wb) begin
      check({tag, " wb ctrl"}, ctrl, wb_ctrl);
      check({tag, " wb dm"}, dm_addr, dm);
      exp_cnt++;
      tick();
    end
  endtask

  initial begin
    fill_nop();
    mem[0] = 16'h1805;
    mem[1] = 16'h0000;
    do_reset();
    check("rst ctrl", ctrl, 0);
    check("rst pm_addr", pm_addr, 0);
    check("rst dm_addr", dm_addr, 0);
    check("rst ext", operand_ext, 0);
    check("rst halted", halted, 0);
    check("rst cnt", cycle_count, 0);
    tick(3);
    check("idle cnt", cycle_count, 0);
    check("idle halted", halted, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr("ldi5", 0, 5, 5, 7'b0100100, 1'b0, 7'b0);
    run_instr("hlt", 1, 0, 0, 7'b0, 1'b0, 7'b0);
    check("p1 halted", halted, 1);
    check("p1 cnt", cycle_count, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("p1 halted sticky", halted, 1);
    check("p1 cnt frozen", cycle_count, 6);
    check("p1 halt ctrl", ctrl, 0);
    check("p1 halt pc", pm_addr, 1);

    fill_nop();
    mem[0] = 16'h1FFF;
    mem[1] = 16'h2803;
    mem[2] = 16'h1018;
    mem[3] = 16'h3018;
    mem[4] = 16'h0860;
    mem[5] = 16'hF800;
    mem[6] = 16'h3802;
    mem[7] = 16'h2001;
    mem[8] = 16'h0000;
    do_reset();
    start = 1'b1;
    tick();
    run_instr("ldi-1", 0, 16'h7FF, 16'hFFFF, 7'b0100100, 1'b0, 7'b0);
    run_instr("addi3", 1, 3, 3, 7'b1010100, 1'b0, 7'b0);
    run_instr("ld18", 2, 16'h18, 16'h18, 7'b0000010, 1'b1, 7'b0000100);
    run_instr("sub18", 3, 16'h18, 16'h18, 7'b0000010, 1'b1, 7'b1001100);
    run_instr("sto60", 4, 16'h60, 16'h60, 7'b0000001, 1'b0, 7'b0);
    run_instr("undef", 5, 0, 0, 7'b0, 1'b0, 7'b0);
    run_instr("subi2", 6, 2, 2, 7'b1011100, 1'b0, 7'b0);
    run_instr("add1", 7, 1, 1, 7'b0000010, 1'b1, 7'b1000100);
    run_instr("hlt2", 8, 0, 0, 7'b0, 1'b0, 7'b0);
    tick(2);
    start = 1'b0;
    check("p2 halted", halted, 1);
    check("p2 cnt", cycle_count, 30);
    check("p2 halt pc", pm_addr, 8);

    fill_nop();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3 * 2047);
    check("wrap pc top", pm_addr, 2047);
    check("wrap cnt top", cycle_count, 6141);
    tick(3);
    check("wrap pc zero", pm_addr, 0);
    check("wrap cnt", cycle_count, 6144);
    check("wrap halted", halted, 0);

    fill_nop();
    mem[0] = 16'h2005;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    check("rstwb exec ctrl", ctrl, 7'b0000010);
    tick();
    check("rstwb wb ctrl", ctrl, 7'b1000100);
    reset = 1'b1;
    tick();
    check("rstwb ctrl", ctrl, 0);
    check("rstwb pm_addr", pm_addr, 0);
    check("rstwb dm_addr", dm_addr, 0);
    check("rstwb ext", operand_ext, 0);
    check("rstwb cnt", cycle_count, 0);
    check("rstwb halted", halted, 0);
    reset = 1'b0;
    tick(3);
    check("rstwb idle ctrl", ctrl, 0);
    check("rstwb idle cnt", cycle_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
